kdtree_stream_loader: RTL

KDTREE_STREAM_LOADER -- requirements
Module: kdtree_stream_loader

---
 rtl/kdtree_stream_loader_pkg.sv | 23 ++
 rtl/kdtree_stream_loader_patch_assembler.sv | 48 ++++
 rtl/kdtree_stream_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/kdtree_stream_loader_pkg.sv
// Shared types and width helpers for the k-d tree stream loader.
// The checksum output is built only when KDTREE_LOADER_CHECKSUM_EN is defined.
package kdtree_stream_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NODES,
    ST_LEAVES,
    ST_QUERIES
  } load_state_t;

  // Width of an index able to address n entries; never below one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_NUM_LEAVES = 64;
  localparam int unsigned DEF_LEAF_SIZE  = 8;
  localparam int unsigned DEF_NODE_AW    = addr_w(DEF_NUM_LEAVES - 1);
  localparam int unsigned DEF_LEAF_AW    = addr_w(DEF_NUM_LEAVES);
  localparam int unsigned DEF_SLOT_AW    = addr_w(DEF_LEAF_SIZE);

endpackage

// File: rtl/kdtree_stream_loader_patch_assembler.sv
// Collects PATCH_SIZE stream words into one patch; the first word pushed
// ends up in the least significant DATA_WIDTH bits.
module patch_assembler
  import kdtree_stream_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned PATCH_SIZE = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             push,
  input  logic [DATA_WIDTH-1:0]            word,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] patch,
  output logic                             full,
  output logic                             last
);

  localparam int unsigned PW = PATCH_SIZE * DATA_WIDTH;
  localparam int unsigned CW = addr_w(PATCH_SIZE + 1);

  logic [CW-1:0] count;
  logic [PW-1:0] shifted;

  generate
    if (PATCH_SIZE > 1) begin : g_shift
      assign shifted = {word, patch[PW-1:DATA_WIDTH]};
    end else begin : g_single
      assign shifted = word;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      patch <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push && !full) begin
      patch <= shifted;
      count <= count + 1'b1;
    end
  end

  assign full = (count == CW'(PATCH_SIZE));
  assign last = (count == CW'(PATCH_SIZE - 1));

endmodule

// File: rtl/kdtree_stream_loader.sv
// Streams k-d tree nodes, leaf patches and query patches from an input FIFO.
// Optional checksum output is enabled by defining KDTREE_LOADER_CHECKSUM_EN.
module kdtree_stream_loader
  import kdtree_stream_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned PATCH_SIZE = 5,
  parameter int unsigned LEAF_SIZE  = 8,
  parameter int unsigned NUM_LEAVES = 64,
  parameter int unsigned NUM_QUERYS = 494
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load_kdtree,
  input  logic                                  load_query,
  input  logic                                  in_valid,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  output logic                                  in_deq,
  output logic                                  node_wen,
  output logic [addr_w(NUM_LEAVES-1)-1:0]       node_waddr,
  output logic [DATA_WIDTH-1:0]                 node_idx,
  output logic [DATA_WIDTH-1:0]                 node_median,
  output logic                                  leaf_wen,
  output logic [addr_w(NUM_LEAVES)-1:0]         leaf_waddr,
  output logic [addr_w(LEAF_SIZE)-1:0]          leaf_wslot,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0]      leaf_wpatch,
  output logic [DATA_WIDTH-1:0]                 leaf_wpidx,
  output logic                                  query_valid,
  input  logic                                  query_ready,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0]      query_patch,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
`ifdef KDTREE_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]                           checksum
`endif
);

  localparam int unsigned NUM_NODES = NUM_LEAVES - 1;
  localparam int unsigned NODE_AW   = addr_w(NUM_NODES);
  localparam int unsigned LEAF_AW   = addr_w(NUM_LEAVES);
  localparam int unsigned SLOT_AW   = addr_w(LEAF_SIZE);
  localparam int unsigned QUERY_CW  = addr_w(NUM_QUERYS);
  localparam int unsigned PW        = PATCH_SIZE * DATA_WIDTH;

  load_state_t state;

  logic [NODE_AW-1:0]    node_cnt;
  logic                  node_half;
  logic [DATA_WIDTH-1:0] idx_reg;
  logic [LEAF_AW-1:0]    leaf_cnt;
  logic [SLOT_AW-1:0]    slot_cnt;
  logic [QUERY_CW-1:0]   query_cnt;

  logic          asm_clear;
  logic          asm_push;
  logic          asm_full;
  logic          asm_last;
  logic [PW-1:0] asm_patch;

  logic start;
  logic slot_last;
  logic leaf_last;
  logic handshake;

  assign start     = load_kdtree || load_query;
  assign slot_last = (slot_cnt == SLOT_AW'(LEAF_SIZE - 1));
  assign leaf_last = slot_last && (leaf_cnt == LEAF_AW'(NUM_LEAVES - 1));
  assign handshake = query_valid && query_ready;

  // A pending query patch keeps the assembler full, which blocks further pops.
  always_comb begin
    in_deq = 1'b0;
    case (state)
      ST_NODES:   in_deq = in_valid;
      ST_LEAVES:  in_deq = in_valid;
      ST_QUERIES: in_deq = in_valid && !asm_full;
      default:    in_deq = 1'b0;
    endcase
  end

  assign asm_push  = in_deq && !asm_full && (state == ST_LEAVES || state == ST_QUERIES);
  assign asm_clear = (state == ST_IDLE)
                  || (state == ST_LEAVES && in_deq && asm_full)
                  || (state == ST_QUERIES && handshake);

  patch_assembler #(
    .DATA_WIDTH (DATA_WIDTH),
    .PATCH_SIZE (PATCH_SIZE)
  ) u_asm (
    .clk   (clk),
    .rst   (rst),
    .clear (asm_clear),
    .push  (asm_push),
    .word  (in_data),
    .patch (asm_patch),
    .full  (asm_full),
    .last  (asm_last)
  );

  assign query_patch = asm_patch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      node_wen    <= 1'b0;
      node_waddr  <= '0;
      node_idx    <= '0;
      node_median <= '0;
      leaf_wen    <= 1'b0;
      leaf_waddr  <= '0;
      leaf_wslot  <= '0;
      leaf_wpatch <= '0;
      leaf_wpidx  <= '0;
      query_valid <= 1'b0;
      node_cnt    <= '0;
      node_half   <= 1'b0;
      idx_reg     <= '0;
      leaf_cnt    <= '0;
      slot_cnt    <= '0;
      query_cnt   <= '0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      node_wen <= 1'b0;
      leaf_wen <= 1'b0;
      if (state != ST_IDLE && start) err <= 1'b1;

      case (state)
        ST_IDLE: begin
          node_cnt  <= '0;
          node_half <= 1'b0;
          leaf_cnt  <= '0;
          slot_cnt  <= '0;
          query_cnt <= '0;
          if (load_kdtree) begin
            state <= ST_NODES;
            busy  <= 1'b1;
          end else if (load_query) begin
            state <= ST_QUERIES;
            busy  <= 1'b1;
          end
        end

        ST_NODES: begin
          if (in_deq) begin
            if (!node_half) begin
              idx_reg   <= in_data;
              node_half <= 1'b1;
            end else begin
              node_half   <= 1'b0;
              node_wen    <= 1'b1;
              node_waddr  <= node_cnt;
              node_idx    <= idx_reg;
              node_median <= in_data;
              if (node_cnt == NODE_AW'(NUM_NODES - 1)) begin
                node_cnt <= '0;
                state    <= ST_LEAVES;
              end else begin
                node_cnt <= node_cnt + 1'b1;
              end
            end
          end
        end

        ST_LEAVES: begin
          // With the patch already full, the popped word is its index.
          if (in_deq && asm_full) begin
            leaf_wen    <= 1'b1;
            leaf_waddr  <= leaf_cnt;
            leaf_wslot  <= slot_cnt;
            leaf_wpatch <= asm_patch;
            leaf_wpidx  <= in_data;
            if (slot_last) begin
              slot_cnt <= '0;
              leaf_cnt <= leaf_cnt + 1'b1;
            end else begin
              slot_cnt <= slot_cnt + 1'b1;
            end
            if (leaf_last) begin
              leaf_cnt <= '0;
              state    <= ST_QUERIES;
            end
          end
        end

        ST_QUERIES: begin
          if (handshake) begin
            query_valid <= 1'b0;
            if (query_cnt == QUERY_CW'(NUM_QUERYS - 1)) begin
              query_cnt <= '0;
              state     <= ST_IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              query_cnt <= query_cnt + 1'b1;
            end
          end else if (in_deq && asm_last) begin
            query_valid <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef KDTREE_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (state == ST_IDLE && start) begin
      checksum <= '0;
    end else if (in_deq) begin
      checksum <= checksum + 16'(in_data);
    end
  end
`endif

endmodule
